lsu_dmem_ctrl: RTL and testbench

//   Load/store unit between the core MEM stage and the 4-bank byte-lane data memory
//   (1-cycle registered read, per-lane write strobes). It converts byte addresses and

---
 rtl/lsu_dmem_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_lsu_dmem_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_dmem_ctrl.sv
// Load/store unit between the core MEM stage and a 4-bank byte-lane data memory.
// Produces lane strobes and shifted store data, splits word-straddling accesses, and extends load data.
module lsu_dmem_ctrl #(
    parameter int DMEM_ADDR_WIDTH = 12
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_req_valid,
    output logic                       o_req_ready,
    input  logic                       i_req_we,
    input  logic [2:0]                 i_req_funct3,
    input  logic [31:0]                i_req_addr,
    input  logic [31:0]                i_req_wdata,
    output logic                       o_rsp_valid,
    output logic [31:0]                o_rsp_rdata,
    output logic                       o_rsp_err,
    output logic [DMEM_ADDR_WIDTH-1:0] o_mem_addr,
    output logic                       o_mem_write,
    output logic                       o_mem_read,
    output logic [3:0]                 o_mem_size,
    output logic [31:0]                o_mem_din,
    input  logic [31:0]                i_mem_dout
);
    localparam int W = DMEM_ADDR_WIDTH;

    // Handshake: a request transfers on a rising edge where i_req_valid && o_req_ready;
    // the core must hold its fields stable while valid is high and ready is low.
    typedef enum logic [2:0] {IDLE, ST_HI, LD_WAIT, LD_LO, LD_HI} state_t;
    state_t state, state_nxt;

    logic [1:0]   req_off;
    logic [3:0]   req_mask;
    logic [7:0]   req_m8;
    logic         req_split;
    logic         req_illegal;
    logic         accept;
    logic         go;
    logic [31:0]  lo_din;
    logic [31:0]  hi_din;
    logic [5:0]   hi_shamt;
    logic [W-1:0] hi_addr;

    logic [2:0]   r_f3;
    logic [1:0]   r_off;
    logic [W-1:0] r_hi_addr;
    logic [3:0]   r_hi_mask;
    logic [31:0]  r_hi_din;
    logic [31:0]  r_lo;

    logic         rsp_valid_q;
    logic [31:0]  rsp_rdata_q;
    logic         rsp_err_q;

    logic         unused_addr_hi;
    assign unused_addr_hi = ^i_req_addr[31:W];

    // Shift the two-word window down by the byte offset, then extend to the access size.
    function automatic logic [31:0] fmt_load(input logic [63:0] raw, input logic [1:0] off,
                                             input logic [2:0] f3);
        logic [63:0] v;
        v = raw >> {off, 3'b000};
        case (f3)
            3'b000:  fmt_load = {{24{v[7]}}, v[7:0]};
            3'b001:  fmt_load = {{16{v[15]}}, v[15:0]};
            3'b100:  fmt_load = {24'h0, v[7:0]};
            3'b101:  fmt_load = {16'h0, v[15:0]};
            default: fmt_load = v[31:0];
        endcase
    endfunction

    always_comb begin
        req_off = i_req_addr[1:0];
        case (i_req_funct3[1:0])
            2'b00:   req_mask = 4'h1;
            2'b01:   req_mask = 4'h3;
            default: req_mask = 4'hF;
        endcase
        req_m8      = {4'h0, req_mask} << req_off;
        req_split   = |req_m8[7:4];
        req_illegal = (i_req_funct3[1:0] == 2'b11) ||
                      (i_req_funct3[2] && (i_req_funct3[1] || i_req_we));
        accept      = i_req_valid && (state == IDLE);
        go          = accept && !req_illegal;
        lo_din      = i_req_wdata << {req_off, 3'b000};
        hi_shamt    = 6'd32 - {1'b0, req_off, 3'b000};
        hi_din      = i_req_wdata >> hi_shamt;
        hi_addr     = {i_req_addr[W-1:2], 2'b00} + W'(4);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (go) begin
                    if (i_req_we) state_nxt = req_split ? ST_HI : IDLE;
                    else          state_nxt = req_split ? LD_LO : LD_WAIT;
                end
            end
            LD_LO:   state_nxt = LD_HI;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_req_ready = (state == IDLE);
        o_mem_addr  = '0;
        o_mem_write = 1'b0;
        o_mem_read  = 1'b0;
        o_mem_size  = 4'h0;
        o_mem_din   = 32'h0;
        case (state)
            IDLE: begin
                if (go) begin
                    o_mem_addr  = i_req_addr[W-1:0];
                    o_mem_write = i_req_we;
                    o_mem_read  = !i_req_we;
                    o_mem_size  = req_m8[3:0];
                    o_mem_din   = i_req_we ? lo_din : 32'h0;
                end
            end
            ST_HI: begin
                o_mem_addr  = r_hi_addr;
                o_mem_write = 1'b1;
                o_mem_size  = r_hi_mask;
                o_mem_din   = r_hi_din;
            end
            LD_LO: begin
                o_mem_addr = r_hi_addr;
                o_mem_read = 1'b1;
                o_mem_size = r_hi_mask;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_f3        <= 3'h0;
            r_off       <= 2'h0;
            r_hi_addr   <= '0;
            r_hi_mask   <= 4'h0;
            r_hi_din    <= 32'h0;
            r_lo        <= 32'h0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            if (go) begin
                r_f3      <= i_req_funct3;
                r_off     <= req_off;
                r_hi_addr <= hi_addr;
                r_hi_mask <= req_m8[7:4];
                r_hi_din  <= hi_din;
            end
            case (state)
                IDLE: begin
                    // Illegal requests and single-word stores complete in the accept cycle.
                    if (accept && (req_illegal || (i_req_we && !req_split))) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= req_illegal;
                        rsp_rdata_q <= 32'h0;
                    end
                end
                ST_HI: begin
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= 32'h0;
                end
                LD_WAIT: begin
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= fmt_load({32'h0, i_mem_dout}, r_off, r_f3);
                end
                LD_LO: r_lo <= i_mem_dout;
                LD_HI: begin
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= fmt_load({i_mem_dout, r_lo}, r_off, r_f3);
                end
                default: ;
            endcase
        end
    end

    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_rdata = rsp_rdata_q;
    assign o_rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// Bench for lsu_dmem_ctrl: byte-array reference memory predicts every response,
// a monitor pops expected responses as the DUT presents them.
module tb_lsu_dmem_ctrl;
    localparam int W   = 12;
    localparam int MSZ = 4096;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_req_valid;
    logic          o_req_ready;
    logic          i_req_we;
    logic [2:0]    i_req_funct3;
    logic [31:0]   i_req_addr;
    logic [31:0]   i_req_wdata;
    logic          o_rsp_valid;
    logic [31:0]   o_rsp_rdata;
    logic          o_rsp_err;
    logic [W-1:0]  o_mem_addr;
    logic          o_mem_write;
    logic          o_mem_read;
    logic [3:0]    o_mem_size;
    logic [31:0]   o_mem_din;
    logic [31:0]   i_mem_dout = 32'h0;

    lsu_dmem_ctrl #(.DMEM_ADDR_WIDTH(W)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_we(i_req_we), .i_req_funct3(i_req_funct3),
        .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
        .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
        .o_mem_addr(o_mem_addr), .o_mem_write(o_mem_write), .o_mem_read(o_mem_read),
        .o_mem_size(o_mem_size), .o_mem_din(o_mem_din), .i_mem_dout(i_mem_dout)
    );

    // ---------------- clock / reset / cycle counter ----------------
    always #5 clk = ~clk;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // ---------------- data memory environment ----------------
    logic [7:0] dmem [MSZ];
    logic [7:0] ref_mem [MSZ];

    always @(posedge clk) begin
        if (o_mem_read)
            i_mem_dout <= {dmem[{o_mem_addr[W-1:2], 2'd3}], dmem[{o_mem_addr[W-1:2], 2'd2}],
                           dmem[{o_mem_addr[W-1:2], 2'd1}], dmem[{o_mem_addr[W-1:2], 2'd0}]};
        if (o_mem_write)
            for (int k = 0; k < 4; k++)
                if (o_mem_size[k]) dmem[{o_mem_addr[W-1:2], 2'(k)}] <= o_mem_din[8*k +: 8];
    end

    // ---------------- scoreboard: {due cycle, err, rdata} ----------------
    logic [64:0] exp_q[$];
    logic [64:0] mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (o_rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_rsp", {31'b0, o_rsp_valid}, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("rsp_cycle", cyc, mon_e[64:33]);
                    chk("rsp_rdata", o_rsp_rdata, mon_e[31:0]);
                    chk("rsp_err", {31'b0, o_rsp_err}, {31'b0, mon_e[32]});
                end
            end else if (exp_q.size() > 0 && exp_q[0][64:33] < cyc) begin
                mon_e = exp_q.pop_front();
                chk("rsp_missing", {31'b0, o_rsp_valid}, 32'd1);
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic int acc_bytes(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [W-1:0] a);
        logic [31:0] v;
        int n;
        v = 32'h0;
        n = acc_bytes(f3);
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[(int'(a) + i) % MSZ];
        if (!f3[2] && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
        if (!f3[2] && n == 2 && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    logic [W-1:0] last_addr;
    logic [31:0]  last_din;
    logic [3:0]   last_size;

    // ---------------- driver ----------------
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd);
        int guard, n, lat, o;
        logic illegal, split;
        logic [3:0] sb;
        logic [31:0] rd, exp_din, lane_m;
        i_req_valid = 1'b1; i_req_we = we; i_req_funct3 = f3;
        i_req_addr = addr; i_req_wdata = wd;
        guard = 0;
        @(negedge clk);
        while (!o_req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!o_req_ready) begin
            chk("accept_timeout", {31'b0, o_req_ready}, 32'd1);
            i_req_valid = 1'b0;
            return;
        end
        illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (we && f3[2]);
        n = acc_bytes(f3);
        o = int'(addr[1:0]);
        split = (o + n) > 4;
        sb = 4'h0; exp_din = 32'h0; lane_m = 32'h0;
        for (int i = 0; i < n; i++)
            if (o + i < 4) begin
                sb[o + i] = 1'b1;
                exp_din[8*(o + i) +: 8] = wd[8*i +: 8];
                lane_m[8*(o + i) +: 8]  = 8'hFF;
            end
        last_addr = o_mem_addr; last_din = o_mem_din; last_size = o_mem_size;
        if (illegal) begin
            chk("illegal_no_access", {30'b0, o_mem_read, o_mem_write}, 32'd0);
            rd = 32'h0; lat = 1;
        end else begin
            chk("lo_strobe", {28'b0, o_mem_size}, {28'b0, sb});
            chk("lo_rw", {30'b0, o_mem_read, o_mem_write}, {30'b0, ~we, we});
            chk("lo_addr", {20'b0, o_mem_addr}, {20'b0, addr[W-1:0]});
            if (we) begin
                chk("lo_din", o_mem_din & lane_m, exp_din);
                for (int i = 0; i < n; i++) ref_mem[(int'(addr[W-1:0]) + i) % MSZ] = wd[8*i +: 8];
                rd = 32'h0; lat = split ? 2 : 1;
            end else begin
                rd = ref_load(f3, addr[W-1:0]); lat = split ? 3 : 2;
            end
        end
        exp_q.push_back({32'(cyc + lat), illegal, rd});
        @(posedge clk);
        #1;
        i_req_valid = 1'b0;
        i_req_we = 1'($urandom); i_req_funct3 = 3'($urandom);
        i_req_addr = $urandom; i_req_wdata = $urandom;
    endtask

    // ---------------- stimulus ----------------
    logic [7:0]  b4, b5;
    logic        r_we;
    logic [2:0]  r_f3;
    logic [31:0] r_addr;
    int          gap, guard;

    initial begin
        for (int i = 0; i < MSZ; i++) begin
            dmem[i] = 8'($urandom);
            ref_mem[i] = dmem[i];
        end
        i_req_valid = 1'b0; i_req_we = 1'b0; i_req_funct3 = 3'h0;
        i_req_addr = 32'h0; i_req_wdata = 32'h0;
        #1;
        chk("reset_rsp_valid", {31'b0, o_rsp_valid}, 32'd0);
        chk("reset_rsp_err", {31'b0, o_rsp_err}, 32'd0);
        chk("reset_rsp_rdata", o_rsp_rdata, 32'd0);
        chk("reset_mem", {o_mem_din[15:0], o_mem_addr, o_mem_size},
            32'd0);
        chk("reset_mem_rw", {30'b0, o_mem_read, o_mem_write}, 32'd0);
        chk("reset_ready", {31'b0, o_req_ready}, 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Aligned word store/load.
        issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        chk("sw_din", last_din, 32'hDEADBEEF);
        issue(1'b0, 3'b010, 32'h10, 32'h0);

        // Byte store at lane 3, signed and unsigned reload.
        issue(1'b1, 3'b000, 32'h13, 32'h80);
        chk("sb_strobe", {28'b0, last_size}, 32'h8);
        chk("sb_din", last_din, 32'h80000000);
        issue(1'b0, 3'b000, 32'h13, 32'h0);
        issue(1'b0, 3'b100, 32'h13, 32'h0);

        // Split word store across 0x20/0x24.
        issue(1'b1, 3'b010, 32'h22, 32'h11223344);
        chk("split_lo_strobe", {28'b0, last_size}, 32'hC);
        chk("split_lo_din", last_din, 32'h33440000);
        chk("split_hi_addr", {20'b0, o_mem_addr}, 32'h24);
        chk("split_hi_write", {31'b0, o_mem_write}, 32'd1);
        chk("split_hi_strobe", {28'b0, o_mem_size}, 32'h3);
        chk("split_hi_din", o_mem_din, 32'h00001122);
        issue(1'b0, 3'b010, 32'h22, 32'h0);

        // Halfword load wrapping past the top of dmem.
        issue(1'b1, 3'b000, 32'hFFF, 32'hAB);
        issue(1'b1, 3'b000, 32'h000, 32'hCD);
        issue(1'b0, 3'b001, 32'hFFF, 32'h0);
        chk("wrap_hi_addr", {20'b0, o_mem_addr}, 32'h0);
        chk("wrap_hi_read", {31'b0, o_mem_read}, 32'd1);

        // Illegal encodings.
        issue(1'b0, 3'b011, 32'h40, 32'h0);
        issue(1'b1, 3'b100, 32'h44, 32'h55);

        // Reset while the high half of a split store is pending.
        b4 = ref_mem[32'h34]; b5 = ref_mem[32'h35];
        issue(1'b1, 3'b010, 32'h32, 32'hAABBCCDD);
        rst_n = 1'b0;
        void'(exp_q.pop_back());
        ref_mem[32'h34] = b4; ref_mem[32'h35] = b5;
        #1;
        chk("rst_mid_write", {31'b0, o_mem_write}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mid_rsp", {31'b0, o_rsp_valid}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_mid_ready", {31'b0, o_req_ready}, 32'd1);
        chk("rst_lo_b2", {24'b0, dmem[32'h32]}, 32'hDD);
        chk("rst_lo_b3", {24'b0, dmem[32'h33]}, 32'hCC);
        chk("rst_hi_kept", {16'b0, dmem[32'h35], dmem[32'h34]}, {16'b0, b5, b4});
        @(posedge clk);
        #1;
        issue(1'b0, 3'b010, 32'h30, 32'h0);
        issue(1'b0, 3'b010, 32'h34, 32'h0);

        // Randomized traffic, biased toward word and memory-top boundaries.
        for (int k = 0; k < 300; k++) begin
            r_we = 1'($urandom_range(0, 1));
            r_addr = $urandom;
            case ($urandom_range(0, 4))
                0: r_f3 = 3'b000;
                1: r_f3 = 3'b001;
                2: r_f3 = 3'b010;
                3: r_f3 = r_we ? 3'b001 : 3'b100;
                default: r_f3 = r_we ? 3'b010 : 3'b101;
            endcase
            if ($urandom_range(0, 15) == 0) r_f3 = 3'($urandom_range(3, 7));
            if ($urandom_range(0, 3) == 0) r_addr[W-1:2] = 10'h3FF;
            if ($urandom_range(0, 3) == 0) r_addr[W-1:4] = 8'h02;
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
            issue(r_we, r_f3, r_addr, $urandom);
        end

        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        @(negedge clk);
        chk("drain", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
